// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Optional feature macro: MUX_ARB_PRIORITY_EN (fixed high priority for req[0]).
package mux_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int ARB_SEL_W        = 32'd2;
   localparam int ARB_NUM_REQ      = 32'd4;
   localparam int ARB_MAX_HOLD_DEF = 32'd8;

   // One-hot grant vector from a binary requester index.
   function automatic logic [ARB_NUM_REQ-1:0] onehot_from_idx(input logic [ARB_SEL_W-1:0] idx);
      logic [ARB_NUM_REQ-1:0] one;
      one = {{(ARB_NUM_REQ-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational round-robin selection: first active request after last_owner.
// Optional feature macro: MUX_ARB_PRIORITY_EN (req[0] wins every pick).
module rr_pick
   import mux_arb_pkg::*;
#(
   parameter int SEL_W   = ARB_SEL_W,
   parameter int NUM_REQ = ARB_NUM_REQ
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last_owner,
   output logic [SEL_W-1:0]   pick_idx,
   output logic               pick_valid
);

   // Walk offsets from farthest to nearest so the nearest active request overrides.
   always_comb begin
      logic [SEL_W-1:0] cand;
      pick_idx   = last_owner;
      pick_valid = 1'b0;
      cand       = last_owner;
      for (int off = NUM_REQ; off >= 1; off--) begin
         cand       = last_owner + SEL_W'(off);
         pick_idx   = req[cand] ? cand : pick_idx;
         pick_valid = pick_valid | req[cand];
      end
`ifdef MUX_ARB_PRIORITY_EN
      pick_idx   = req[0] ? {SEL_W{1'b0}} : pick_idx;
      pick_valid = pick_valid | req[0];
`endif
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with a bounded
// tenure (hold counter) and a timeout pulse when a tenure expires.
// Optional feature macro: MUX_ARB_PRIORITY_EN (handled inside rr_pick).
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int SEL_W    = ARB_SEL_W,
   parameter int NUM_REQ  = ARB_NUM_REQ,
   parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
   parameter int HOLD_W   = 32'd8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [SEL_W-1:0]   selector,
   output logic               grant_valid,
   output logic               timeout
);

   arb_state_t        state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [SEL_W-1:0]  last_owner;
   logic [SEL_W-1:0]  search_base;
   logic [SEL_W-1:0]  pick_idx;
   logic              pick_valid;
   logic              drop;
   logic              expire;
   logic              rel;

   // While granted, a pick only matters on release, when the current owner becomes last_owner.
   always_comb begin
      search_base = (state == GRANT) ? selector : last_owner;
      drop        = ~req[selector];
      expire      = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
      rel         = drop | expire;
   end

   rr_pick #(
      .SEL_W   (SEL_W),
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req        (req),
      .last_owner (search_base),
      .pick_idx   (pick_idx),
      .pick_valid (pick_valid)
   );

   // Arbitration FSM, hold counter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         hold_cnt    <= {HOLD_W{1'b0}};
         last_owner  <= SEL_W'(NUM_REQ - 1);
         grant       <= {NUM_REQ{1'b0}};
         selector    <= {SEL_W{1'b0}};
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               timeout  <= 1'b0;
               hold_cnt <= {HOLD_W{1'b0}};
               if (pick_valid) begin
                  state       <= GRANT;
                  grant       <= onehot_from_idx(pick_idx);
                  selector    <= pick_idx;
                  grant_valid <= 1'b1;
               end else begin
                  grant       <= {NUM_REQ{1'b0}};
                  grant_valid <= 1'b0;
               end
            end
            GRANT: begin
               if (rel) begin
                  // A drop takes precedence over expiry: no timeout pulse then.
                  timeout    <= expire & ~drop;
                  last_owner <= selector;
                  hold_cnt   <= {HOLD_W{1'b0}};
                  if (pick_valid) begin
                     grant    <= onehot_from_idx(pick_idx);
                     selector <= pick_idx;
                  end else begin
                     state       <= IDLE;
                     grant       <= {NUM_REQ{1'b0}};
                     grant_valid <= 1'b0;
                  end
               end else begin
                  timeout  <= 1'b0;
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            default: begin
               state       <= IDLE;
               hold_cnt    <= {HOLD_W{1'b0}};
               grant       <= {NUM_REQ{1'b0}};
               grant_valid <= 1'b0;
               timeout     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD 8 and 2) share clock, reset and
// requests; each is compared every cycle against a tenure-level reference model.
module tb_mux_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;

   logic [3:0] grant_a, grant_b;
   logic [1:0] sel_a, sel_b;
   logic       gv_a, gv_b, to_a, to_b;

   int n_checks = 0;
   int n_fail = 0;

   // reference model state, index 0 = MAX_HOLD 8, index 1 = MAX_HOLD 2
   int m_max[2] = '{8, 2};
   bit m_busy[2];
   int m_owner[2];
   int m_len[2];
   int m_last[2];
   bit m_to[2];
   int to_a_count;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.MAX_HOLD(8)) u_a (
      .clk(clk), .rst_n(rst_n), .req(req),
      .grant(grant_a), .selector(sel_a), .grant_valid(gv_a), .timeout(to_a)
   );

   mux_rr_arbiter #(.MAX_HOLD(2)) u_b (
      .clk(clk), .rst_n(rst_n), .req(req),
      .grant(grant_b), .selector(sel_b), .grant_valid(gv_b), .timeout(to_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input int last, input logic [3:0] r);
`ifdef MUX_ARB_PRIORITY_EN
      if (r[0]) return 0;
`endif
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4]) return (last + k) % 4;
      end
      return last;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 1'b0; m_owner[i] = 0; m_len[i] = 0; m_last[i] = 3; m_to[i] = 1'b0;
      end
   endtask

   // One clock of arbitration for both models given the request vector seen at the edge.
   task automatic model_step(input logic [3:0] r);
      for (int i = 0; i < 2; i++) begin
         bit dropped, expired;
         m_to[i] = 1'b0;
         if (!m_busy[i]) begin
            if (r != 4'b0000) begin
               m_owner[i] = pick(m_last[i], r); m_busy[i] = 1'b1; m_len[i] = 1;
            end
         end else begin
            dropped = !r[m_owner[i]];
            expired = (m_len[i] == m_max[i]);
            if (dropped || expired) begin
               m_to[i] = expired && !dropped;
               m_last[i] = m_owner[i];
               if (r != 4'b0000) begin
                  m_owner[i] = pick(m_last[i], r); m_len[i] = 1;
               end else begin
                  m_busy[i] = 1'b0;
               end
            end else begin
               m_len[i]++;
            end
         end
      end
   endtask

   task automatic check_all();
      logic [3:0] one;
      one = 4'b0001;
      check_eq("a_grant", 32'(grant_a), m_busy[0] ? 32'(one << m_owner[0]) : 32'd0);
      check_eq("a_sel", 32'(sel_a), 32'(m_owner[0]));
      check_eq("a_valid", 32'(gv_a), 32'(m_busy[0]));
      check_eq("a_timeout", 32'(to_a), 32'(m_to[0]));
      check_eq("b_grant", 32'(grant_b), m_busy[1] ? 32'(one << m_owner[1]) : 32'd0);
      check_eq("b_sel", 32'(sel_b), 32'(m_owner[1]));
      check_eq("b_valid", 32'(gv_b), 32'(m_busy[1]));
      check_eq("b_timeout", 32'(to_b), 32'(m_to[1]));
   endtask

   // Drive r across one rising edge and check at the following falling edge.
   task automatic cycle(input logic [3:0] r);
      req = r;
      model_step(r);
      @(negedge clk);
      to_a_count += int'(to_a);
      check_all();
   endtask

   // Asynchronous reset away from the clock edge; outputs must clear at once.
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      req = 4'b0000;
      model_reset();
      #1;
      check_eq({tag, "_grant"}, 32'({grant_a, grant_b}), 32'd0);
      check_eq({tag, "_valid"}, 32'({gv_a, gv_b, to_a, to_b}), 32'd0);
      check_eq({tag, "_sel"}, 32'({sel_a, sel_b}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int b_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      logic [3:0] r;
      model_reset();
      to_a_count = 0;
      @(negedge clk);
      check_all();
      async_reset("reset0");

      // single requester held 3 cycles then dropped
      cycle(4'b0100);
      check_eq("single_grant", 32'(grant_a), 32'h4);
      check_eq("single_sel", 32'(sel_a), 32'd2);
      cycle(4'b0100);
      cycle(4'b0100);
      cycle(4'b0000);
      check_eq("single_release", 32'(gv_a), 32'd0);
      check_eq("single_no_timeout", 32'(to_a_count), 32'd0);
      cycle(4'b0000);

      // full load rotation on the MAX_HOLD=2 arbiter
      async_reset("reset1");
      for (int k = 0; k < 9; k++) begin
         cycle(4'b1111);
         check_eq("fullload_owner", 32'(sel_b), 32'(b_seq[k]));
         check_eq("fullload_valid", 32'(gv_b), 32'd1);
      end

      // sole requester across two expiries of the MAX_HOLD=8 arbiter
      async_reset("reset2");
      to_a_count = 0;
      for (int k = 1; k <= 20; k++) begin
         cycle(4'b0010);
         check_eq("sole_timeout", 32'(to_a), (k == 9 || k == 17) ? 32'd1 : 32'd0);
      end
      check_eq("sole_timeout_count", 32'(to_a_count), 32'd2);

      // handover on drop: owner 1 gives way to 3 without a bubble
      cycle(4'b1010);
      cycle(4'b1000);
      check_eq("handover_grant", 32'(grant_a), 32'h8);
      check_eq("handover_valid", 32'(gv_a), 32'd1);
      cycle(4'b0000);
      cycle(4'b0000);

      // reset mid-tenure, then first grant goes to requester 0
      async_reset("reset3");
      for (int k = 0; k < 6; k++) cycle(4'b0100);
      async_reset("midtenure");
      cycle(4'b1111);
      check_eq("after_reset_grant", 32'(grant_a), 32'h1);

`ifdef MUX_ARB_PRIORITY_EN
      async_reset("reset_prio");
      cycle(4'b1110);
      cycle(4'b1110);
      cycle(4'b1111);
      check_eq("prio_no_preempt", 32'(grant_a), 32'h2);
      cycle(4'b1101);
      check_eq("prio_wins", 32'(grant_a), 32'h1);
      cycle(4'b1100);
      check_eq("prio_then_rotate", 32'(grant_a), 32'h4);
`endif

      // randomized traffic with occasional request changes and rare resets
      r = 4'b0000;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
         else cycle(r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 selection resource between four requesters.
- Drives the 2-bit `selector` of the downstream 4:1 mux and a one-hot grant back to the requesters.
- Sits between the requesting sources and the shared mux, which is an instance of the team's 4:1 mux.
- Bounds each tenure with a hold counter so no requester can starve the others.

Parameters:
- SEL_W, 2, selector width; fixed by the 4-input mux, must be 2.
- NUM_REQ, 4, number of requesters; must equal 2**SEL_W.
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure; legal range 1..255.
- HOLD_W, 8, width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  request per requester; level-sensitive.
- grant  output  NUM_REQ  one-hot grant, registered.
- selector  output  SEL_W  binary index of the owner; drives the mux select, registered.
- grant_valid  output  1  high while any grant is active; the mux output is meaningful only then.
- timeout  output  1  one-cycle pulse when a tenure ends by hitting MAX_HOLD.

Behaviour:
- Reset (async assert, sync release):
  - grant=0, selector=0, grant_valid=0, timeout=0.
  - state=IDLE, hold_cnt=0, last_owner=NUM_REQ-1, so req[0] has first priority.
- Reset asserted mid-tenure drops all outputs immediately; there is no completion of the tenure.
- All outputs come from flops. Latency from a req rising in IDLE to grant/selector/grant_valid is 1 cycle.
- Round-robin pick:
  - Search order is last_owner+1, +2, +3, +4, modulo NUM_REQ.
  - Pick the first requester with req=1.
  - Wrap-around: after owner 3 the search starts at 0.
- State IDLE:
  - No req: stay IDLE, outputs 0.
  - Any req: go to GRANT with owner=pick, grant=onehot(owner), selector=owner, grant_valid=1, hold_cnt=0.
- State GRANT, each cycle:
  - Release by drop: req[owner]=0.
  - Release by expiry: hold_cnt==MAX_HOLD-1. Assert timeout for the following cycle only.
  - If neither release condition holds, increment hold_cnt.
  - On release, last_owner takes the value of owner.
  - If any req is set (including the old owner's on expiry), pick the next owner with the new last_owner and stay in GRANT with hold_cnt=0. This is a zero-bubble handover: grant_valid stays 1 and grant changes in one edge.
  - If no req is set, go to IDLE and clear the outputs next cycle.
- Sole requester at expiry: it is re-granted with no gap. timeout pulses and hold_cnt restarts.
- Drop and expiry in the same cycle: treat as a drop (no timeout pulse).
- MAX_HOLD=1: every grant lasts exactly one cycle, so rotation happens every cycle under full load.
- Invariants:
  - grant is always one-hot or zero.
  - selector equals the index of the set grant bit.
  - selector holds its last value when grant=0.

Optional Feature:
- MUX_ARB_PRIORITY_EN.
- Defined: req[0] is a fixed high-priority requester.
  - At every pick (IDLE entry or release handover), req[0]=1 wins regardless of last_owner.
  - It never preempts a running tenure.
  - last_owner is still updated, so requesters 1..3 rotate among themselves.
- Undefined: pure round-robin as above; the priority logic is absent from the netlist.

Decomposition:
- Package mux_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - Constants ARB_SEL_W=2, ARB_NUM_REQ=4, ARB_MAX_HOLD_DEF=8.
  - Function onehot_from_idx.
- One combinational sub-module, rr_pick:
  - Inputs: req, last_owner.
  - Outputs: pick_idx, pick_valid.
  - Contains the MUX_ARB_PRIORITY_EN override.
- The top module holds the FSM, the hold counter and the output flops.

Test Plan:
- Single requester, req=4'b0100 held 3 cycles then dropped:
  - grant=4'b0100 and selector=2 from cycle 1.
  - grant_valid low 1 cycle after the drop.
  - timeout never pulses.
- Full load, req=4'b1111 constant, MAX_HOLD=2: owners follow 0,0,1,1,2,2,3,3,0 with grant_valid continuously 1 and a timeout pulse every 2 cycles.
- Expiry with sole requester, req=4'b0010 held 20 cycles, MAX_HOLD=8:
  - grant never drops.
  - timeout pulses at cycles 9 and 17.
  - hold_cnt restarts each time.
- Handover on drop: owner 1 active with req=4'b1010, then req[1] falls. Next edge gives grant=4'b1000 and selector=3 with no idle cycle.
- Reset mid-tenure: owner 2 at hold_cnt=5, rst_n pulled low asynchronously.
  - Outputs are 0 before the next clk edge.
  - After release with req=4'b1111, the first grant goes to 0.
- With MUX_ARB_PRIORITY_EN, req=4'b1110 and owner 1 active, then req[0] rises:
  - Owner 1 keeps its grant until it drops or expires.
  - The next grant goes to 0.
  - When 0 releases, the grant goes to 2.
